lock_access_ctrl: RTL and testbench

Access controller between the button edge detectors and the digital lock. It forwards valid single-button pulses to the lock and watches the lock's per-attempt result. It enforces an inter-press entry timeout, counts failed attempts, imposes a timed lockout after too many failures, and times the open (unlocked) window. At every sequence end it pulses a clear to restart the lock's code entry.

---
 rtl/lock_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_lock_access_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lock_access_ctrl.sv
// Access controller in front of the digital lock: gates presses, times entry/open/lockout windows.
// Optional feature: define LOCKOUT_ESCALATE_EN for doubling lockout durations on repeated lockouts.
module lock_access_ctrl #(
  parameter int MAX_FAILS      = 3,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int LOCKOUT_CYCLES = 250000000,
  parameter int OPEN_CYCLES    = 150000000,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  input  logic       attempt_done,
  input  logic       attempt_ok,
  output logic [3:0] btn_out,
  output logic       lock_clear,
  output logic       unlocked,
  output logic       locked_out,
  output logic [3:0] fail_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ENTRY = 2'b01,
    S_OPEN  = 2'b10,
    S_LOCK  = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_fails, w_fails_nxt;
  logic [3:0]       r_btn, w_btn_nxt;
  logic             r_clear, w_clear_nxt;
  logic             r_unl, r_lko;
  logic             w_press;
  logic             w_cnt_zero;
  logic [3:0]       w_fail_inc;
  logic [CNT_W-1:0] w_lock_dur;

  assign w_press    = $onehot(btn_in);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_fail_inc = (r_fails >= 4'(MAX_FAILS)) ? r_fails : r_fails + 4'd1;

`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] r_level, w_level_nxt;
  assign w_lock_dur = (CNT_W'(LOCKOUT_CYCLES) << r_level) - CNT_W'(1);
`else
  assign w_lock_dur = CNT_W'(LOCKOUT_CYCLES - 1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fails_nxt = r_fails;
    w_btn_nxt   = 4'b0000;
    w_clear_nxt = 1'b0;
`ifdef LOCKOUT_ESCALATE_EN
    w_level_nxt = r_level;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_btn_nxt   = btn_in;
          w_state_nxt = S_ENTRY;
          w_cnt_nxt   = CNT_W'(TIMEOUT_CYCLES - 1);
        end
      end
      S_ENTRY: begin
        // A verdict always wins over a coincident press, which is dropped.
        if (attempt_done && attempt_ok) begin
          w_state_nxt = S_OPEN;
          w_cnt_nxt   = CNT_W'(OPEN_CYCLES - 1);
          w_fails_nxt = 4'd0;
`ifdef LOCKOUT_ESCALATE_EN
          w_level_nxt = 2'd0;
`endif
        end else if (attempt_done) begin
          w_fails_nxt = w_fail_inc;
          w_clear_nxt = 1'b1;
          if (w_fail_inc == 4'(MAX_FAILS)) begin
            w_state_nxt = S_LOCK;
            w_cnt_nxt   = w_lock_dur;
`ifdef LOCKOUT_ESCALATE_EN
            if (r_level != 2'd3) w_level_nxt = r_level + 2'd1;
`endif
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_press) begin
          w_btn_nxt = btn_in;
          w_cnt_nxt = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
          w_clear_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_OPEN: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
          w_clear_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_LOCK: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
          w_fails_nxt = 4'd0;
          w_clear_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fails <= 4'd0;
      r_btn   <= 4'b0000;
      r_clear <= 1'b0;
      r_unl   <= 1'b0;
      r_lko   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fails <= w_fails_nxt;
      r_btn   <= w_btn_nxt;
      r_clear <= w_clear_nxt;
      r_unl   <= (w_state_nxt == S_OPEN);
      r_lko   <= (w_state_nxt == S_LOCK);
    end
  end

`ifdef LOCKOUT_ESCALATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level <= 2'd0;
    else     r_level <= w_level_nxt;
  end
`endif

  assign btn_out    = r_btn;
  assign lock_clear = r_clear;
  assign unlocked   = r_unl;
  assign locked_out = r_lko;
  assign fail_cnt   = r_fails;
  assign state      = r_state;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Scoreboard bench for lock_access_ctrl: a phase-level reference model predicts every output cycle.
module tb_lock_access_ctrl;
  localparam int TMO = 10, LKO = 20, OPN = 5, MXF = 3;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_LOCK = 3;

  typedef struct packed {
    logic [3:0] btn;
    logic       clr;
    logic       unl;
    logic       lko;
    logic [3:0] fc;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] btn_in = 4'b0;
  logic       attempt_done = 1'b0, attempt_ok = 1'b0;
  logic [3:0] btn_out, fail_cnt;
  logic       lock_clear, unlocked, locked_out;
  logic [1:0] state;

  lock_access_ctrl #(.MAX_FAILS(MXF), .TIMEOUT_CYCLES(TMO), .LOCKOUT_CYCLES(LKO),
                     .OPEN_CYCLES(OPN), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .attempt_done(attempt_done),
    .attempt_ok(attempt_ok), .btn_out(btn_out), .lock_clear(lock_clear),
    .unlocked(unlocked), .locked_out(locked_out), .fail_cnt(fail_cnt), .state(state));

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0, cyc_no = 0;
  exp_t q[$];

  // Model: which phase we are in, how many cycles of that phase remain, failures so far.
  int m_mode = M_IDLE, m_left = 0, m_fails = 0, m_lvl = 0;

  function automatic exp_t actual();
    exp_t a;
    a = {btn_out, lock_clear, unlocked, locked_out, fail_cnt, state};
    return a;
  endfunction

  task automatic compare(input string nm, input exp_t a, input exp_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got btn=%b clr=%b unl=%b lko=%b fc=%0d st=%b, expected btn=%b clr=%b unl=%b lko=%b fc=%0d st=%b",
               nm, cyc_no, a.btn, a.clr, a.unl, a.lko, a.fc, a.st,
               e.btn, e.clr, e.unl, e.lko, e.fc, e.st);
    end
  endtask

  task automatic model_step(input logic [3:0] b, input logic d, input logic ok, output exp_t e);
    bit vp;
    vp = ($countones(b) == 1);
    e = '0;
    case (m_mode)
      M_IDLE: if (vp) begin e.btn = b; m_mode = M_ENTRY; m_left = TMO; end
      M_ENTRY: begin
        if (d && ok) begin
          m_mode = M_OPEN; m_left = OPN; m_fails = 0; m_lvl = 0;
        end else if (d) begin
          m_fails = (m_fails + 1 > MXF) ? MXF : m_fails + 1;
          e.clr = 1'b1;
          if (m_fails == MXF) begin
            m_mode = M_LOCK;
`ifdef LOCKOUT_ESCALATE_EN
            m_left = LKO * (2 ** m_lvl);
            if (m_lvl < 3) m_lvl++;
`else
            m_left = LKO;
`endif
          end else m_mode = M_IDLE;
        end else if (vp) begin
          e.btn = b; m_left = TMO;
        end else begin
          m_left--;
          if (m_left == 0) begin m_mode = M_IDLE; e.clr = 1'b1; end
        end
      end
      M_OPEN: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_IDLE; e.clr = 1'b1; end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_IDLE; m_fails = 0; e.clr = 1'b1; end
      end
    endcase
    e.unl = (m_mode == M_OPEN);
    e.lko = (m_mode == M_LOCK);
    e.fc  = 4'(m_fails);
    e.st  = 2'(m_mode);
  endtask

  task automatic cyc(input logic [3:0] b, input logic d = 1'b0, input logic ok = 1'b0);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; btn_in = b; attempt_done = d; attempt_ok = ok;
    model_step(b, d, ok, e);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000);
  endtask

  task automatic fail_once();
    cyc(4'b0001);
    cyc(4'b0000, 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear before any edge.
  task automatic do_reset(input int hold);
    @(negedge clk);
    rst = 1'b1; btn_in = 4'b0; attempt_done = 1'b0; attempt_ok = 1'b0;
    #1 compare("async_reset", actual(), exp_t'(0));
    m_mode = M_IDLE; m_left = 0; m_fails = 0; m_lvl = 0;
    q.push_back(exp_t'(0));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      q.push_back(exp_t'(0));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("scoreboard", actual(), e);
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1 compare("reset_state", actual(), exp_t'(0));
    // Valid press forwarded, multi-bit press dropped
    idle(1);
    cyc(4'b0001);
    cyc(4'b0011);
    // Successful attempt and OPEN window with blocked presses
    cyc(4'b0010);
    cyc(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(4'b0100);
    // Three failures into lockout, presses blocked throughout
    for (int k = 0; k < 3; k++) begin fail_once(); idle(1); end
    for (int i = 0; i < LKO + 3; i++) cyc(4'b1000);
`ifdef LOCKOUT_ESCALATE_EN
    for (int k = 0; k < 3; k++) begin fail_once(); idle(1); end
    for (int i = 0; i < 2 * LKO + 3; i++) cyc(4'b0001);
`endif
    // Entry timeout, then a late press reloading it
    cyc(4'b1000);
    idle(TMO + 2);
    cyc(4'b1000);
    idle(TMO - 2);
    cyc(4'b0100);
    idle(TMO + 2);
    // Press coincident with a failed verdict
    cyc(4'b0001);
    cyc(4'b0010, 1'b1, 1'b0);
    idle(2);
    // Reset in the middle of a lockout
    fail_once(); idle(1);
    fail_once(); idle(5);
    do_reset(2);
    cyc(4'b0100);
    idle(3);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] b;
      logic d, ok;
      b  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      d  = ($urandom_range(0, 5) == 0);
      ok = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) do_reset(1 + $urandom_range(0, 1));
      else cyc(b, d, ok);
    end
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
